dac_multichannel: RTL and testbench
===================================

# dac_multichannel

Parametrised multi-channel behavioural DAC model for the sine-wave bench. It replaces the single-channel, combinationally weighted converter with N_CH channels of N_BITS codes, accepted through a valid/ready write port into a small FIFO. Each channel has a shadow and an active register. Writes are drained by a load/settle state machine that models interface time. Outputs update either immediately after settling or on a simultaneous LDAC strobe.

## Interface
- N_BITS, 12: code width per channel (1..24)
- N_CH, 4: number of output channels (≥1)
- VREF, 3.3: real reference voltage
- DEPTH, 4: write FIFO depth (power of two, ≥2)
- SETTLE_CYCLES, 2: cycles a load occupies the converter (≥1)
- UPDATE_MODE, 0: 0 = immediate (active updates after settle), 1 = latched (active updates only on ldac)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  converter enable; low freezes the FSM and draining
- wr_valid  in  1  write request
- wr_ready  out  1  FIFO not full
- wr_ch  in  $clog2(N_CH) (min 1)  target channel
- wr_code  in  N_BITS  unsigned code
- ldac  in  1  load-all strobe (latched mode only)
- a_out  out  real [N_CH]  analog outputs
- busy  out  1  FSM in SETTLE
- fifo_level  out  $clog2(DEPTH)+1  entries held
- err_ch  out  1  sticky: a write to channel ≥ N_CH was accepted

## Operation
- Reset (rst_n low, asynchronous) forces:
  - all shadow and active registers to 0, so every a_out = 0.0
  - FIFO empty, fifo_level 0, wr_ready 1
  - busy 0, err_ch 0, FSM in IDLE
- Write acceptance:
  - a write is accepted on a rising edge with wr_valid && wr_ready; it pushes {wr_ch, wr_code}
  - wr_ready = (fifo_level != DEPTH); a write while full is not accepted and is not an error
  - acceptance is independent of en
- FSM states:
  - IDLE: if en && FIFO non-empty, pop the head at this edge. If ch < N_CH, shadow[ch] ← code; otherwise drop the entry and set err_ch. Load counter with SETTLE_CYCLES−1 and go to SETTLE. Invalid-channel pops also pass through SETTLE.
  - SETTLE: busy=1. While en, decrement the counter each edge. At the edge where counter==0, go to IDLE; in immediate mode (valid channel) active[ch] ← shadow[ch] at that edge. en low holds the counter.
- Same-edge push and pop is allowed and leaves the level unchanged; a push while full is impossible by construction.
- Latched mode:
  - ldac high at an edge copies every shadow to active
  - a shadow written at the same edge is not included; it goes out on the next ldac
  - ldac is independent of en and FSM state
- Immediate mode: ldac is ignored.
- Conversion: a_out[c] = VREF * active[c] / 2.0**N_BITS, a continuous assignment from active.
  - the MSB alone gives VREF/2
  - full scale is VREF*(1−2^−N_BITS)
- err_ch is cleared only by reset.

## Timing
- A write accepted at edge k:
  - is popped at edge k+1 (FIFO was empty, FSM idle, en high)
  - in immediate mode, a_out changes at edge k+1+SETTLE_CYCLES
- Throughput is one load per SETTLE_CYCLES+1 cycles, because IDLE costs one cycle per entry.
- busy rises at the pop edge and falls at the settle-expiry edge.
- Latched mode: a_out changes at the ldac edge; zero-cycle latency from the strobe.
- fifo_level and wr_ready update at the edge of the push or pop.
- Reset asserted mid-SETTLE aborts the load and zeroes all outputs immediately, without waiting for clk.

## Structure
- Package dac_pkg holds:
  - the FSM state enum (IDLE, SETTLE)
  - the packed FIFO entry typedef
  - function code_to_volt(code, vref, nbits) returning real
- Sub-module dac_wr_fifo: a parametrised synchronous FIFO with level output, async active-low reset, and push/pop/full/empty.
- The top level holds the FSM, the shadow and active arrays, and the conversion.

## Test plan
- Reset values: with rst_n low mid-run, all a_out = 0.0, wr_ready=1, fifo_level=0, busy=0, err_ch=0, independent of clk.
- Immediate mode, N_BITS=12, SETTLE_CYCLES=2: write ch1=0x800 at edge k, then a_out[1] = 1.65 at edge k+3; write 0xFFF gives 3.2992. Other channels stay at 0.0.
- FIFO full: 6 back-to-back writes with en=0 and DEPTH=4 accept exactly 4 (wr_ready low after the 4th). Raising en drains all 4 in order, 3 cycles apart.
- Latched mode: write ch0=0x400 and ch2=0xC00, so a_out stays 0.0. ldac then gives 0.825 and 2.475 at the same edge. A write to ch0 on the same edge as ldac is not reflected until the next ldac.
- N_CH=3: a write to ch3 is accepted, err_ch=1 after its pop, and no a_out changes.
- en dropped mid-SETTLE holds busy and the counter; the update lands the corresponding number of cycles later after en returns.

Source files
------------

// File: rtl/dac_multichannel_pkg.sv
// Shared types and helpers for the multi-channel DAC model: FSM states,
// the FIFO entry layout (sized for the widest legal channel/code) and code-to-volt conversion.
package dac_pkg;

  localparam int MAX_CH_W = 8;
  localparam int MAX_BITS = 24;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic [MAX_BITS-1:0] code;
  } fifo_entry_t;

  function automatic real code_to_volt(input logic [MAX_BITS-1:0] code, input real vref,
                                       input int nbits);
    return vref * real'(code) / (2.0 ** nbits);
  endfunction

endpackage

// File: rtl/dac_multichannel_if.sv
// Write port of the DAC: a channel/code pair qualified by valid/ready.
// Handshake: a transfer happens on a rising clk edge where wr_valid && wr_ready are both high;
// wr_ready depends only on FIFO occupancy, never on wr_valid.
interface dac_multichannel_if #(
  parameter int N_BITS = 12,
  parameter int N_CH   = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic [N_BITS-1:0] wr_code;

  modport master (output wr_valid, output wr_ch, output wr_code, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_code, output wr_ready);
endinterface

// File: rtl/dac_wr_fifo.sv
// Synchronous write FIFO with occupancy output; push while full and pop while empty are ignored.
module dac_wr_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW + 1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dac_multichannel.sv
// Behavioural N-channel DAC: FIFO-buffered writes, shadow/active registers per channel,
// a load/settle FSM modelling interface time, and immediate or LDAC-latched output update.
module dac_multichannel
  import dac_pkg::*;
#(
  parameter int  N_BITS        = 12,
  parameter int  N_CH          = 4,
  parameter real VREF          = 3.3,
  parameter int  DEPTH         = 4,
  parameter int  SETTLE_CYCLES = 2,
  parameter int  UPDATE_MODE   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   ldac,
  dac_multichannel_if.slave      wr,
  output real                    a_out [N_CH],
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   err_ch,
  output state_t                 dbg_state
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  fifo_entry_t         push_entry;
  fifo_entry_t         head;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                ch_ok;
  logic                load_active;
  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nx;
  logic [MAX_CH_W-1:0] cur_ch;
  logic                cur_valid;
  logic [N_BITS-1:0]   shadow [N_CH];
  logic [N_BITS-1:0]   active [N_CH];
  logic                unused_head;

  assign push_entry.ch   = MAX_CH_W'(wr.wr_ch);
  assign push_entry.code = MAX_BITS'(wr.wr_code);
  assign push            = wr.wr_valid && wr.wr_ready;
  assign wr.wr_ready     = !full;
  assign ch_ok           = (int'(head.ch) < N_CH);
  assign unused_head     = ^head;

  dac_wr_fifo #(
    .W     ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_ch    <= '0;
      cur_valid <= 1'b0;
      err_ch    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (pop) begin
        cur_ch    <= head.ch;
        cur_valid <= ch_ok;
        if (!ch_ok) err_ch <= 1'b1;
      end
    end
  end

  // Invalid-channel entries still occupy a full settle period so throughput is uniform.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pop         = 1'b0;
    load_active = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          pop      = 1'b1;
          cnt_nx   = CNT_W'(SETTLE_CYCLES - 1);
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (en) begin
          if (cnt == '0) begin
            state_nx    = IDLE;
            load_active = cur_valid && (UPDATE_MODE == 0);
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state == SETTLE);
  assign dbg_state = state;

  // LDAC copies the pre-edge shadow, so a shadow loaded on the same edge waits for the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        shadow[c] <= '0;
        active[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (pop && head.ch == MAX_CH_W'(c)) shadow[c] <= head.code[N_BITS-1:0];
        if (UPDATE_MODE != 0) begin
          if (ldac) active[c] <= shadow[c];
        end else if (load_active && cur_ch == MAX_CH_W'(c)) begin
          active[c] <= shadow[c];
        end
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_conv
    assign a_out[c] = code_to_volt(MAX_BITS'(active[c]), VREF, N_BITS);
  end

endmodule

// File: tb/tb_dac_multichannel.sv
// Directed bench for dac_multichannel: immediate, latched and 3-channel instances share clk/rst/en/ldac.
module tb_dac_multichannel;
  import dac_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic ldac = 1'b0;

  always #5 clk = ~clk;

  dac_multichannel_if #(.N_BITS(12), .N_CH(4)) if_a ();
  dac_multichannel_if #(.N_BITS(12), .N_CH(4)) if_b ();
  dac_multichannel_if #(.N_BITS(12), .N_CH(3)) if_c ();

  real         a_a [4];
  real         a_b [4];
  real         a_c [3];
  logic        busy_a, busy_b, busy_c;
  logic [2:0]  lvl_a, lvl_b, lvl_c;
  logic        err_a, err_b, err_c;
  state_t      st_a, st_b, st_c;

  dac_multichannel #(.N_BITS(12), .N_CH(4), .VREF(3.3), .DEPTH(4), .SETTLE_CYCLES(2),
                     .UPDATE_MODE(0)) u_imm (
    .clk(clk), .rst_n(rst_n), .en(en), .ldac(ldac), .wr(if_a.slave), .a_out(a_a),
    .busy(busy_a), .fifo_level(lvl_a), .err_ch(err_a), .dbg_state(st_a));

  dac_multichannel #(.N_BITS(12), .N_CH(4), .VREF(3.3), .DEPTH(4), .SETTLE_CYCLES(2),
                     .UPDATE_MODE(1)) u_lat (
    .clk(clk), .rst_n(rst_n), .en(en), .ldac(ldac), .wr(if_b.slave), .a_out(a_b),
    .busy(busy_b), .fifo_level(lvl_b), .err_ch(err_b), .dbg_state(st_b));

  dac_multichannel #(.N_BITS(12), .N_CH(3), .VREF(3.3), .DEPTH(4), .SETTLE_CYCLES(2),
                     .UPDATE_MODE(0)) u_ch3 (
    .clk(clk), .rst_n(rst_n), .en(en), .ldac(ldac), .wr(if_c.slave), .a_out(a_c),
    .busy(busy_c), .fifo_level(lvl_c), .err_ch(err_c), .dbg_state(st_c));

  int n_assert = 0;
  int n_fail   = 0;
  logic [13:0] exp_q[$];
  logic        mon_busy_q = 1'b0;

  function automatic real volt(input int code);
    return 3.3 * real'(code) / 4096.0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_real(input string tag, input real obs, input real exp, input real tol);
    n_assert++;
    assert ((obs - exp) < tol && (exp - obs) < tol) else begin
      n_fail++;
      $error("FAIL %s: observed %f expected %f", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one write for exactly one edge; acc says whether the FIFO should take it.
  task automatic write(input int dut, input int ch, input int code, input bit acc);
    case (dut)
      0: begin if_a.wr_valid = 1'b1; if_a.wr_ch = 2'(ch); if_a.wr_code = 12'(code);
               chk("wr_ready_a", if_a.wr_ready, acc); end
      1: begin if_b.wr_valid = 1'b1; if_b.wr_ch = 2'(ch); if_b.wr_code = 12'(code);
               chk("wr_ready_b", if_b.wr_ready, acc); end
      default: begin if_c.wr_valid = 1'b1; if_c.wr_ch = 2'(ch); if_c.wr_code = 12'(code);
               chk("wr_ready_c", if_c.wr_ready, acc); end
    endcase
    if (dut == 0 && acc) exp_q.push_back({2'(ch), 12'(code)});
    tick();
    if_a.wr_valid = 1'b0;
    if_b.wr_valid = 1'b0;
    if_c.wr_valid = 1'b0;
  endtask

  // Scoreboard: every settle expiry on the immediate instance must land the oldest queued write.
  always @(posedge clk) begin
    logic [13:0] e;
    #1;
    if (rst_n && mon_busy_q && !busy_a) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected_update: observed update expected none");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_real("sb_update", a_a[e[13:12]], volt(int'(e[11:0])), 1e-6);
      end
    end
    mon_busy_q = busy_a;
  end

  initial begin
    int falls [8];
    int nf;
    logic pb;

    if_a.wr_valid = 1'b0; if_a.wr_ch = '0; if_a.wr_code = '0;
    if_b.wr_valid = 1'b0; if_b.wr_ch = '0; if_b.wr_code = '0;
    if_c.wr_valid = 1'b0; if_c.wr_ch = '0; if_c.wr_code = '0;

    // Reset state before any clock edge
    #2;
    for (int c = 0; c < 4; c++) chk_real("rst_a_out", a_a[c], 0.0, 1e-9);
    chk("rst_ready", if_a.wr_ready, 1);
    chk("rst_level", lvl_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_err", err_a, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Immediate mode latency: write at edge k, output at k+3
    write(0, 1, 'h800, 1);
    chk("lat_level_k", lvl_a, 1);
    chk("lat_busy_k", busy_a, 0);
    tick();
    chk("lat_busy_k1", busy_a, 1);
    chk("lat_level_k1", lvl_a, 0);
    chk_real("lat_out_k1", a_a[1], 0.0, 1e-9);
    tick();
    chk_real("lat_out_k2", a_a[1], 0.0, 1e-9);
    tick();
    chk_real("lat_out_k3", a_a[1], 1.65, 1e-9);
    chk("lat_busy_k3", busy_a, 0);
    chk_real("lat_other0", a_a[0], 0.0, 1e-9);
    chk_real("lat_other2", a_a[2], 0.0, 1e-9);
    chk_real("lat_other3", a_a[3], 0.0, 1e-9);

    write(0, 1, 'hFFF, 1);
    repeat (4) tick();
    chk_real("full_scale", a_a[1], 3.2992, 1e-4);

    // FIFO fill with converter disabled, then drain
    en = 1'b0;
    for (int i = 0; i < 4; i++) write(0, i, (i + 1) * 'h100, 1);
    write(0, 0, 'h555, 0);
    write(0, 0, 'h666, 0);
    chk("full_level", lvl_a, 4);
    chk("full_busy", busy_a, 0);
    en = 1'b1;
    nf = 0;
    pb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pb && !busy_a && nf < 8) begin
        falls[nf] = i;
        nf++;
      end
      pb = busy_a;
    end
    chk("drain_count", nf, 4);
    for (int i = 1; i < 4; i++) chk("drain_spacing", falls[i] - falls[i-1], 3);
    chk("drain_level", lvl_a, 0);
    chk_real("drain_ch3", a_a[3], volt('h400), 1e-9);

    // en dropped mid-settle holds the counter for three edges
    write(0, 2, 'h123, 1);
    tick();
    chk("hold_busy_pop", busy_a, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_busy", busy_a, 1);
      chk_real("hold_old", a_a[2], volt('h300), 1e-9);
    end
    en = 1'b1;
    tick();
    chk_real("hold_resume1", a_a[2], volt('h300), 1e-9);
    tick();
    chk_real("hold_land", a_a[2], volt('h123), 1e-9);
    chk("hold_busy_done", busy_a, 0);
    chk("sb_drained", exp_q.size(), 0);

    // Latched mode
    write(1, 0, 'h400, 1);
    write(1, 2, 'hC00, 1);
    repeat (8) tick();
    chk_real("lat_hold0", a_b[0], 0.0, 1e-9);
    chk_real("lat_hold2", a_b[2], 0.0, 1e-9);
    ldac = 1'b1;
    tick();
    ldac = 1'b0;
    chk_real("ldac_ch0", a_b[0], 0.825, 1e-9);
    chk_real("ldac_ch2", a_b[2], 2.475, 1e-9);
    chk_real("imm_ignores_ldac", a_a[2], volt('h123), 1e-9);
    write(1, 0, 'h200, 1);
    ldac = 1'b1;
    tick();
    ldac = 1'b0;
    chk("ldac_same_busy", busy_b, 1);
    chk_real("ldac_same_edge", a_b[0], 0.825, 1e-9);
    repeat (4) tick();
    chk_real("ldac_wait", a_b[0], 0.825, 1e-9);
    ldac = 1'b1;
    tick();
    ldac = 1'b0;
    chk_real("ldac_next", a_b[0], 0.4125, 1e-9);
    chk_real("ldac_keep2", a_b[2], 2.475, 1e-9);

    // Out-of-range channel on the 3-channel instance
    write(2, 3, 'hABC, 1);
    chk("err_before_pop", err_c, 0);
    tick();
    chk("err_after_pop", err_c, 1);
    chk("err_busy", busy_c, 1);
    repeat (3) tick();
    for (int c = 0; c < 3; c++) chk_real("err_no_out", a_c[c], 0.0, 1e-9);
    chk("err_sticky", err_c, 1);
    chk("err_ready", if_c.wr_ready, 1);

    // Asynchronous reset in the middle of a settle
    write(0, 3, 'h7FF, 1);
    tick();
    chk("mid_busy", busy_a, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    for (int c = 0; c < 4; c++) chk_real("arst_a_out", a_a[c], 0.0, 1e-9);
    chk("arst_busy", busy_a, 0);
    chk("arst_level", lvl_a, 0);
    chk("arst_ready", if_a.wr_ready, 1);
    chk("arst_err_c", err_c, 0);
    chk_real("arst_b0", a_b[0], 0.0, 1e-9);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
